// File: rtl/div_ctrl_pkg.sv
// Shared constants and types for the RV32M divide sequencer.
package div_ctrl_pkg;

    localparam int DATA_W = 32;

    // func7 marking the M-extension group
    localparam logic [6:0] INST_MUL_DIV = 7'b0000001;

    // func3 encodings of the divide group
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_END  = 2'd2
    } div_state_e;

    // DIV and REM take absolute values and restore the sign at the end
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient
    function automatic logic is_rem_op(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

    // Only the quotient ops produce all-ones on a zero divisor
    function automatic logic is_quo_op(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_DIVU);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU/REM/REMU.
// Holds the pipeline from issue until the single-cycle write-back strobe.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        busy_o,
    output logic        hold_flag_o
);

    div_state_e  state;
    div_state_e  state_next;

    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic [31:0] dvd;
    logic [31:0] dsr;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        neg_quo;
    logic        neg_rem;

    logic        start_ok;
    logic        sgn_op;
    logic        dsr_zero;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] trial;
    logic [31:0] res_sel;
    logic        res_neg;

    assign start_ok = start_i & ~flush_i & (state == DIV_IDLE);
    assign sgn_op   = is_signed_op(op_i);
    assign dsr_zero = (divisor_i == 32'd0);

    // Two's complement magnitude; 0x8000_0000 maps to itself, which is
    // exactly the unsigned magnitude the restoring loop needs.
    assign dividend_abs = (sgn_op && dividend_i[31]) ? (~dividend_i + 32'd1) : dividend_i;
    assign divisor_abs  = (sgn_op && divisor_i[31])  ? (~divisor_i + 32'd1)  : divisor_i;

    // 33-bit trial subtraction; bit 32 set means the shifted remainder is below the divisor
    assign trial = {rem, dvd[31]} - {1'b0, dsr};

    assign busy_o      = (state != DIV_IDLE);
    assign hold_flag_o = start_ok | busy_o;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: zero divisor skips the iteration phase entirely
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (start_ok) begin
                    state_next = dsr_zero ? DIV_END : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (flush_i) begin
                    state_next = DIV_IDLE;
                end else if (cnt == 5'd31) begin
                    state_next = DIV_END;
                end
            end
            DIV_END: begin
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // Operand latch at issue and one restoring step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 3'd0;
            rd_q    <= 5'd0;
            cnt     <= 5'd0;
            dvd     <= 32'd0;
            dsr     <= 32'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_ok) begin
                        op_q <= op_i;
                        rd_q <= rd_addr_i;
                        cnt  <= 5'd0;
                        if (dsr_zero) begin
                            // Preload the architected divide-by-zero results
                            dvd     <= dividend_i;
                            dsr     <= divisor_i;
                            quo     <= 32'hFFFF_FFFF;
                            rem     <= dividend_i;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                        end else begin
                            dvd     <= dividend_abs;
                            dsr     <= divisor_abs;
                            quo     <= 32'd0;
                            rem     <= 32'd0;
                            neg_quo <= sgn_op & (dividend_i[31] ^ divisor_i[31]);
                            neg_rem <= sgn_op & dividend_i[31];
                        end
                    end
                end
                DIV_CALC: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= {rem[30:0], dvd[31]};
                        quo <= {quo[30:0], 1'b0};
                    end
                    dvd <= {dvd[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Write-back outputs, live only in END; a flush there suppresses the strobe
    always_comb begin
        result_o  = 32'd0;
        rd_addr_o = 5'd0;
        rd_wen_o  = 1'b0;
        res_sel   = is_rem_op(op_q) ? rem : quo;
        res_neg   = is_rem_op(op_q) ? neg_rem : neg_quo;
        if (state == DIV_END) begin
            result_o  = res_neg ? (~res_sel + 32'd1) : res_sel;
            rd_addr_o = rd_q;
            rd_wen_o  = ~flush_i;
        end
    end

    // Keeps the shared helper visibly tied to this block's opcode set
    logic unused_quo_op;
    assign unused_quo_op = is_quo_op(op_q) & (INST_MUL_DIV == 7'd0);

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected write-backs are queued at issue
// and matched (value, destination, cycle) when rd_wen_o fires.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;
    logic        busy_o;
    logic        hold_flag_o;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .rd_addr_i   (rd_addr_i),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .rd_addr_o   (rd_addr_o),
        .rd_wen_o    (rd_wen_o),
        .busy_o      (busy_o),
        .hold_flag_o (hold_flag_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference results from SystemVerilog arithmetic plus the RV32M corner rules
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb2;
        logic signed [31:0] sr;
        sa  = a;
        sb2 = b;
        if (b == 32'd0) return (op == 3'b100 || op == 3'b101) ? 32'hFFFF_FFFF : a;
        case (op)
            3'b101:  return a / b;
            3'b111:  return a % b;
            3'b100: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb2;
                return sr;
            end
            default: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sr = sa % sb2;
                return sr;
            end
        endcase
    endfunction

    // Monitor: match every write strobe against the scoreboard, and check that
    // outputs stay zero whenever no write is being presented.
    always @(negedge clk) begin
        #2;
        if (rd_wen_o) begin
            if (sb.size() == 0) begin
                chk("wen_unexpected", rd_wen_o, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("rd_addr", rd_addr_o, e.rd);
                chk("wen_cycle", cyc, e.cyc);
            end
        end else if (!flush_i) begin
            chk("idle_outputs", {result_o, rd_addr_o, rd_wen_o}, 38'd0);
        end
    end

    // Drive a start in the current cycle (called just after a negedge); returns in cycle 1
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        exp_t e;
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        if (push) begin
            e.res = exp;
            e.rd  = rd;
            e.cyc = cyc + ((b == 32'd0) ? 1 : 33);
            sb.push_back(e);
        end
        #1 chk("hold_c0", hold_flag_o, 1'b1);
        @(negedge clk);
        start_i    = 1'b0;
        op_i       = 3'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        rd_addr_i  = 5'($urandom);
    endtask

    // Full divide: hold must stay high through END and drop in the following cycle
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        lat = (b == 32'd0) ? 1 : 33;
        issue(op, a, b, rd, exp, 1'b1);
        for (int c = 1; c <= lat; c++) begin
            #1 chk("hold_busy", hold_flag_o, 1'b1);
            @(negedge clk);
        end
        #1;
        chk("hold_release", hold_flag_o, 1'b0);
        chk("busy_release", busy_o, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        op_i       = 3'd0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        rd_addr_i  = 5'd0;
        flush_i    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_hold", hold_flag_o, 1'b0);
        chk("rst_outs", {result_o, rd_addr_o, rd_wen_o}, 38'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived results
        run(3'b101, 32'd100, 32'd7, 5'd5, 32'd14);
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
        run(3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF);
        run(3'b111, 32'd5, 32'd0, 5'd15, 32'd5);
        run(3'b100, 32'hFFFF_FFFB, 32'd0, 5'd16, 32'hFFFF_FFFF);
        run(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd17, 32'hFFFF_FFFB);
        run(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd18, 32'd1);
        run(3'b111, 32'hFFFF_FFFF, 32'd16, 5'd19, 32'd15);

        // Flush in CALC cycle 10; a new start in cycle 11 writes in cycle 44
        issue(3'b100, 32'd50, 32'd5, 5'd3, 32'd10, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1 chk("flush_calc_hold", hold_flag_o, 1'b1);
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("flush_calc_idle", busy_o, 1'b0);
        run(3'b101, 32'd99, 32'd9, 5'd4, 32'd11);

        // Flush in END cycle 33 suppresses the strobe
        issue(3'b111, 32'd17, 32'd5, 5'd6, 32'd2, 1'b0);
        repeat (32) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_end_wen", rd_wen_o, 1'b0);
        chk("flush_end_busy", busy_o, 1'b1);
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("flush_end_idle", busy_o, 1'b0);

        // A second start in cycle 5 must not disturb the active divide
        issue(3'b101, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b1);
        repeat (4) @(negedge clk);
        start_i    = 1'b1;
        op_i       = 3'b111;
        dividend_i = 32'd77;
        divisor_i  = 32'd3;
        rd_addr_i  = 5'd9;
        #1 chk("restart_hold", hold_flag_o, 1'b1);
        @(negedge clk);
        start_i = 1'b0;
        repeat (28) @(negedge clk);
        #1 chk("restart_idle", busy_o, 1'b0);

        // Asynchronous reset in cycle 20 clears everything at once
        issue(3'b100, 32'd1234, 32'd7, 5'd8, 32'd176, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_hold", hold_flag_o, 1'b0);
        chk("midrst_outs", {result_o, rd_addr_o, rd_wen_o}, 38'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1 chk("midrst_stays_idle", busy_o, 1'b0);
        @(negedge clk);

        // Back-to-back random divides, each started in the cycle after END
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) b = 32'd0;
            if (i == 7) a = 32'h8000_0000;
            run(op, a, b, 5'($urandom), ref_div(op, a, b));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
